// File: rtl/key_matrix_scan.sv
// Row/column key-matrix scanner: drives one row at a time, debounces every key,
// and emits press/release events on a valid/ready port, stalling the scan rather than drop one.
module key_matrix_scan #(
  parameter int unsigned NUM_ROWS              = 4,
  parameter int unsigned NUM_ROWS_WIDTH        = 2,
  parameter int unsigned NUM_COLS              = 4,
  parameter int unsigned NUM_COLS_WIDTH        = 2,
  parameter int unsigned SCAN_DELAY            = 1000,
  parameter int unsigned SCAN_DELAY_WIDTH      = 10,
  parameter int unsigned DEBOUNCE_SCANS        = 4,
  parameter int unsigned DEBOUNCE_WIDTH        = 3,
  parameter bit          ROW_OUTPUT_ACTIVE_LOW = 1'b1,
  parameter bit          COL_INPUT_ACTIVE_LOW  = 1'b1
) (
  input  logic                         clk,
  input  logic                         i_rst_n,
  input  logic [NUM_COLS-1:0]          i_cols,
  output logic [NUM_ROWS-1:0]          o_rows,
  output logic [NUM_ROWS*NUM_COLS-1:0] o_keys,
  output logic                         o_key_valid,
  input  logic                         i_key_ready,
  output logic [NUM_ROWS_WIDTH-1:0]    o_key_row,
  output logic [NUM_COLS_WIDTH-1:0]    o_key_col,
  output logic                         o_key_pressed
);

  localparam int unsigned NUM_KEYS  = NUM_ROWS * NUM_COLS;
  localparam int unsigned KEY_IDX_W = NUM_ROWS_WIDTH + NUM_COLS_WIDTH;

  localparam logic [0:0] S_DWELL = 1'b0;
  localparam logic [0:0] S_EVAL  = 1'b1;

  logic [NUM_COLS-1:0]         r_sync1, r_sync2, r_sample;
  logic [0:0]                  r_state;
  logic [SCAN_DELAY_WIDTH-1:0] r_dwell;
  logic [NUM_ROWS_WIDTH-1:0]   r_row;
  logic [NUM_COLS_WIDTH-1:0]   r_col;
  logic [NUM_KEYS-1:0]         r_keys;
  logic [DEBOUNCE_WIDTH-1:0]   r_cnt [NUM_KEYS];
  logic                        r_valid;
  logic [NUM_ROWS_WIDTH-1:0]   r_ev_row;
  logic [NUM_COLS_WIDTH-1:0]   r_ev_col;
  logic                        r_ev_pressed;

  logic [NUM_COLS-1:0]       w_raw;
  logic [KEY_IDX_W-1:0]      w_key_idx;
  logic                      w_key_raw, w_key_state, w_differ, w_hit;
  logic                      w_eval, w_stall, w_load, w_last_col, w_last_dwell;
  logic [DEBOUNCE_WIDTH-1:0] w_cnt_inc;
  logic [NUM_ROWS_WIDTH-1:0] w_next_row;
  logic [NUM_ROWS-1:0]       w_row_onehot;

  assign w_raw        = COL_INPUT_ACTIVE_LOW ? ~r_sync2 : r_sync2;
  assign w_key_idx    = KEY_IDX_W'(r_row) * KEY_IDX_W'(NUM_COLS) + KEY_IDX_W'(r_col);
  assign w_key_raw    = r_sample[r_col];
  assign w_key_state  = r_keys[w_key_idx];
  assign w_cnt_inc    = r_cnt[w_key_idx] + 1'b1;
  assign w_differ     = w_key_raw != w_key_state;
  assign w_hit        = w_differ && (w_cnt_inc == DEBOUNCE_WIDTH'(DEBOUNCE_SCANS));
  assign w_eval       = r_state == S_EVAL;
  // A key that needs to emit while the previous event is still unaccepted freezes the scan.
  assign w_stall      = w_eval && w_hit && r_valid && !i_key_ready;
  assign w_load       = w_eval && w_hit && !w_stall;
  assign w_last_col   = r_col == NUM_COLS_WIDTH'(NUM_COLS - 1);
  assign w_last_dwell = r_dwell == SCAN_DELAY_WIDTH'(SCAN_DELAY - 1);
  assign w_next_row   = (r_row == NUM_ROWS_WIDTH'(NUM_ROWS - 1)) ? '0 : r_row + 1'b1;
  assign w_row_onehot = NUM_ROWS'(1) << r_row;

  assign o_rows        = ROW_OUTPUT_ACTIVE_LOW ? ~w_row_onehot : w_row_onehot;
  assign o_keys        = r_keys;
  assign o_key_valid   = r_valid;
  assign o_key_row     = r_ev_row;
  assign o_key_col     = r_ev_col;
  assign o_key_pressed = r_ev_pressed;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= {NUM_COLS{COL_INPUT_ACTIVE_LOW}};
      r_sync2 <= {NUM_COLS{COL_INPUT_ACTIVE_LOW}};
    end else begin
      r_sync1 <= i_cols;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= S_DWELL;
      r_dwell  <= '0;
      r_row    <= '0;
      r_col    <= '0;
      r_sample <= '0;
    end else if (r_state == S_DWELL) begin
      if (w_last_dwell) begin
        r_sample <= w_raw;
        r_col    <= '0;
        r_state  <= S_EVAL;
      end else begin
        r_dwell <= r_dwell + 1'b1;
      end
    end else if (!w_stall) begin
      if (w_last_col) begin
        r_row   <= w_next_row;
        r_dwell <= '0;
        r_state <= S_DWELL;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_keys <= '0;
      for (int unsigned i = 0; i < NUM_KEYS; i++) r_cnt[i] <= '0;
    end else if (w_eval && !w_stall) begin
      if (!w_differ) begin
        r_cnt[w_key_idx] <= '0;
      end else if (w_hit) begin
        r_keys[w_key_idx] <= w_key_raw;
        r_cnt[w_key_idx]  <= '0;
      end else begin
        r_cnt[w_key_idx] <= w_cnt_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid      <= 1'b0;
      r_ev_row     <= '0;
      r_ev_col     <= '0;
      r_ev_pressed <= 1'b0;
    end else if (w_load) begin
      r_valid      <= 1'b1;
      r_ev_row     <= r_row;
      r_ev_col     <= r_col;
      r_ev_pressed <= w_key_raw;
    end else if (r_valid && i_key_ready) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_key_matrix_scan.sv
// Bench for key_matrix_scan: a physical key matrix drives the columns from o_rows, and a
// scan-level debounce model predicts key state and the ordered event stream.
module tb_key_matrix_scan;

  localparam int NR    = 4;
  localparam int NC    = 4;
  localparam int SD    = 4;
  localparam int DS    = 3;
  localparam int SLOT  = SD + NC;
  localparam int SCAN  = NR * SLOT;
  localparam int NSCAN = 40;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  i_cols;
  logic [3:0]  o_rows;
  logic [15:0] o_keys;
  logic        o_key_valid;
  logic        i_key_ready;
  logic [1:0]  o_key_row;
  logic [1:0]  o_key_col;
  logic        o_key_pressed;

  logic [15:0] phys;
  int          n_total = 0;
  int          n_bad   = 0;
  int          cyc;
  bit          model_on = 1'b0;
  logic [15:0] m_state;
  int          m_cnt [16];
  logic [4:0]  exp_q [$];
  logic [15:0] dir_pat [13];

  always #5 clk = ~clk;

  key_matrix_scan #(
    .NUM_ROWS(4), .NUM_ROWS_WIDTH(2), .NUM_COLS(4), .NUM_COLS_WIDTH(2),
    .SCAN_DELAY(SD), .SCAN_DELAY_WIDTH(3), .DEBOUNCE_SCANS(DS), .DEBOUNCE_WIDTH(2),
    .ROW_OUTPUT_ACTIVE_LOW(1'b1), .COL_INPUT_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .i_rst_n(rst_n), .i_cols(i_cols), .o_rows(o_rows), .o_keys(o_keys),
    .o_key_valid(o_key_valid), .i_key_ready(i_key_ready), .o_key_row(o_key_row),
    .o_key_col(o_key_col), .o_key_pressed(o_key_pressed)
  );

  // A column reads low when any currently driven (low) row has that key held down.
  always_comb begin
    i_cols = 4'hF;
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++)
        if (!o_rows[r] && phys[r*NC+c]) i_cols[c] = 1'b0;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, wanted %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] exp_rows(input int r);
    logic [3:0] v;
    v    = 4'hF;
    v[r] = 1'b0;
    return v;
  endfunction

  // One full scan visits keys in row-major order, so events are queued in that order.
  task automatic model_scan();
    for (int k = 0; k < 16; k++) begin
      if (phys[k] == m_state[k]) begin
        m_cnt[k] = 0;
      end else begin
        m_cnt[k]++;
        if (m_cnt[k] == DS) begin
          m_state[k] = phys[k];
          m_cnt[k]   = 0;
          exp_q.push_back({2'(k / NC), 2'(k % NC), phys[k]});
        end
      end
    end
  endtask

  task automatic check_event();
    logic [5:0] e;
    e = 6'h00;
    if (exp_q.size() > 0) e = {1'b1, exp_q.pop_front()};
    check_eq("event", 32'({1'b1, o_key_row, o_key_col, o_key_pressed}), 32'(e));
  endtask

  always @(negedge clk) begin
    if (model_on) begin
      check_eq("rows", 32'(o_rows), 32'(exp_rows((cyc / SLOT) % NR)));
      if (o_key_valid && i_key_ready) check_event();
    end
  end

  initial begin
    int w;
    dir_pat = '{16'h0000, 16'h0000, 16'h0200, 16'h0200, 16'h0000, 16'h0000, 16'h0200,
                16'h0200, 16'h0200, 16'h0200, 16'h0000, 16'h0000, 16'h0000};
    rst_n       = 1'b0;
    i_key_ready = 1'b1;
    phys        = '0;
    m_state     = '0;
    for (int k = 0; k < 16; k++) m_cnt[k] = 0;
    repeat (3) @(negedge clk);
    check_eq("rst_rows", 32'(o_rows), 32'(4'b1110));
    check_eq("rst_keys", 32'(o_keys), 32'h0);
    check_eq("rst_valid", 32'(o_key_valid), 32'h0);
    check_eq("rst_payload", 32'({o_key_row, o_key_col, o_key_pressed}), 32'h0);

    rst_n    = 1'b1;
    model_on = 1'b1;
    for (int s = 0; s < NSCAN; s++) begin
      if (s > 0) check_eq("keys", 32'(o_keys), 32'(m_state));
      if (s < 13) begin
        phys = dir_pat[s];
      end else begin
        for (int k = 0; k < 16; k++)
          if ($urandom_range(0, 4) == 0) phys[k] = ~phys[k];
      end
      model_scan();
      repeat (SCAN) @(negedge clk);
    end
    check_eq("keys_final", 32'(o_keys), 32'(m_state));
    repeat (3) @(negedge clk);
    check_eq("evt_drain", 32'(exp_q.size()), 32'h0);
    model_on = 1'b0;

    // Back-pressure: two presses in row 0 with the consumer not ready.
    rst_n       = 1'b0;
    i_key_ready = 1'b0;
    phys        = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    phys  = 16'h0009;
    w = 0;
    while (!o_key_valid && w < 200) begin
      @(negedge clk);
      w++;
    end
    check_eq("stall_valid", 32'(o_key_valid), 32'h1);
    check_eq("stall_evt0", 32'({o_key_row, o_key_col, o_key_pressed}), 32'(5'b00001));
    check_eq("stall_keys0", 32'(o_keys), 32'h0001);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("stall_rows", 32'(o_rows), 32'(4'b1110));
      check_eq("stall_hold", 32'({o_key_valid, o_key_row, o_key_col, o_key_pressed}),
               32'(6'b100001));
    end
    i_key_ready = 1'b1;
    @(negedge clk);
    i_key_ready = 1'b0;
    check_eq("stall_valid2", 32'(o_key_valid), 32'h1);
    check_eq("stall_evt1", 32'({o_key_row, o_key_col, o_key_pressed}), 32'(5'b00111));
    check_eq("stall_keys1", 32'(o_keys), 32'h0009);
    check_eq("stall_next_row", 32'(o_rows), 32'(4'b1101));

    // Asynchronous reset while an event is pending.
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_valid", 32'(o_key_valid), 32'h0);
    check_eq("arst_keys", 32'(o_keys), 32'h0);
    check_eq("arst_rows", 32'(o_rows), 32'(4'b1110));
    check_eq("arst_payload", 32'({o_key_row, o_key_col, o_key_pressed}), 32'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
